npu_out_writer: RTL and testbench

NPU_OUT_WRITER -- requirements
Module: npu_out_writer

---
 rtl/npu_out_writer_if.sv | 14 +
 rtl/npu_out_writer.sv | 161 ++++++++++++++++
 tb/tb_npu_out_writer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_out_writer_if.sv
// Write-beat bus between the NPU output writer (master) and the memory sink (slave).
// A beat transfers on every rising edge where wr_en and wr_ready are both high.
interface npu_out_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BEAT_WIDTH = 72
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BEAT_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (output wr_en, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/npu_out_writer.sv
// Buffers NPU result vectors in a small FIFO and writes each one out as two
// half-vector beats at consecutive addresses, framed by a cfg_start / done pair.
module npu_out_writer #(
    parameter int NPU_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NPU_OUT_NUM*DATA_WIDTH-1:0] NPU_data_in,
    input  logic                              NPU_data_valid_in,
    input  logic                              cfg_start,
    input  logic [ADDR_WIDTH-1:0]             cfg_base_addr,
    input  logic [15:0]                       cfg_pixel_num,
    npu_out_writer_if.master                  wr,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow
);

    localparam int VEC_W  = NPU_OUT_NUM * DATA_WIDTH;
    localparam int BEAT_W = (NPU_OUT_NUM / 2) * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [VEC_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  beat_sel;
    logic [15:0]           pixel_num;
    logic [15:0]           push_cnt;
    logic [15:0]           pop_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [VEC_W-1:0]      head;

    logic fifo_empty;
    logic fifo_full;
    logic start_ok;
    logic want_push;
    logic push;
    logic drop;
    logic accept;
    logic pop;
    logic last_pop;

    assign start_ok   = cfg_start && (state == IDLE);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign head       = mem[rd_ptr];

    assign accept   = !fifo_empty && wr.wr_ready;
    assign pop      = accept && beat_sel;
    assign last_pop = pop && ((pop_cnt + 16'd1) == pixel_num);

    // Vectors beyond the frame length are swallowed; they still never reach the FIFO.
    assign want_push = NPU_data_valid_in && (state == RUN) && (push_cnt < pixel_num);
    assign push      = want_push && (!fifo_full || pop);
    assign drop      = want_push && fifo_full && !pop;

    assign wr.wr_en   = !fifo_empty;
    assign wr.wr_addr = addr;
    assign wr.wr_data = fifo_empty ? '0
                      : (beat_sel ? head[BEAT_W +: BEAT_W] : head[BEAT_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if ((pixel_num == 16'd0) || last_pop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= NPU_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_sel  <= 1'b0;
            pixel_num <= '0;
            push_cnt  <= '0;
            pop_cnt   <= '0;
            addr      <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start_ok) begin
                pixel_num <= cfg_pixel_num;
                addr      <= cfg_base_addr;
                push_cnt  <= '0;
                pop_cnt   <= '0;
                overflow  <= 1'b0;
            end
            if (want_push) begin
                push_cnt <= push_cnt + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (accept) begin
                addr     <= addr + ADDR_WIDTH'(1);
                beat_sel <= !beat_sel;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                pop_cnt <= pop_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_npu_out_writer.sv
// Self-checking bench for npu_out_writer: a queue-based frame model is compared
// against the DUT every cycle, plus directed frames with hand-computed expectations.
module tb_npu_out_writer;

    localparam int NUM   = 18;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int VW    = NUM * DW;
    localparam int BW    = (NUM / 2) * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          start;
    logic          ready;
    logic [VW-1:0] data;
    logic [AW-1:0] base;
    logic [15:0]   pix;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    npu_out_writer_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) wr_if ();
    assign wr_if.wr_ready = ready;

    npu_out_writer #(
        .NPU_OUT_NUM(NUM),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .NPU_data_in      (data),
        .NPU_data_valid_in(valid),
        .cfg_start        (start),
        .cfg_base_addr    (base),
        .cfg_pixel_num    (pix),
        .wr               (wr_if),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference: pending vectors as a queue, beats as front-vector halves.
    bit            model_live = 1'b0;
    bit            m_run;
    bit            m_done;
    bit            m_half;
    bit            m_ovf;
    logic [AW-1:0] m_addr;
    int            m_seen;
    int            m_popped;
    int            m_target;
    logic [VW-1:0] mq[$];

    logic [AW-1:0] log_addr[$];
    logic [BW-1:0] log_data[$];
    int            done_cnt = 0;
    int            beats_at_done = 0;

    bit            p_hold = 1'b0;
    logic [AW-1:0] p_addr;
    logic [BW-1:0] p_data;

    task automatic check_output(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit v, input logic [VW-1:0] d, input bit r);
        valid = v;
        data  = d;
        ready = r;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check_output("done_seen", VW'(done_cnt != d0), VW'(1));
    endtask

    function automatic logic [VW-1:0] make_vec(input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < NUM; c++) v[c*DW +: DW] = DW'(k * 20 + c + 1);
        return v;
    endfunction

    // Beat b of vector k carries channels b*NUM/2 .. b*NUM/2+NUM/2-1, lowest at LSB.
    function automatic logic [BW-1:0] exp_beat(input int k, input int b);
        logic [BW-1:0] e;
        e = '0;
        for (int c = 0; c < NUM / 2; c++) e[c*DW +: DW] = DW'(k * 20 + b * (NUM / 2) + c + 1);
        return e;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < NUM; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_step();
        bit en;
        bit acc;
        bit pop;
        bit keep;
        bit fin;
        if (rst) begin
            m_run      = 1'b0;
            m_done     = 1'b0;
            m_half     = 1'b0;
            m_ovf      = 1'b0;
            m_addr     = '0;
            mq.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            en   = (mq.size() > 0);
            acc  = en && ready;
            pop  = acc && m_half;
            keep = 1'b0;
            fin  = 1'b0;
            if (m_run) begin
                if (valid && m_seen < m_target) begin
                    m_seen++;
                    if (mq.size() < DEPTH || pop) keep = 1'b1;
                    else m_ovf = 1'b1;
                end
                if (acc) begin
                    m_addr++;
                    m_half = !m_half;
                end
                if (pop) begin
                    mq.delete(0);
                    m_popped++;
                end
                if (keep) mq.push_back(data);
                if (m_target == 0 || (pop && m_popped == m_target)) begin
                    m_run = 1'b0;
                    fin   = 1'b1;
                end
            end else if (!m_done && start) begin
                m_run    = 1'b1;
                m_target = int'(pix);
                m_seen   = 0;
                m_popped = 0;
                m_addr   = base;
                m_ovf    = 1'b0;
            end
            m_done = fin;
        end
    endtask

    task automatic compare_cycle();
        logic [BW-1:0] e_data;
        bit            e_en;
        e_en   = (mq.size() > 0);
        e_data = '0;
        if (e_en) e_data = m_half ? mq[0][VW-1:BW] : mq[0][BW-1:0];
        check_output("wr_en", VW'(wr_if.wr_en), VW'(e_en));
        check_output("wr_addr", VW'(wr_if.wr_addr), VW'(m_addr));
        check_output("wr_data", VW'(wr_if.wr_data), VW'(e_data));
        check_output("busy", VW'(busy), VW'(m_run));
        check_output("done", VW'(done), VW'(m_done));
        check_output("overflow", VW'(overflow), VW'(m_ovf));
        if (p_hold) begin
            check_output("hold_en", VW'(wr_if.wr_en), VW'(1));
            check_output("hold_addr", VW'(wr_if.wr_addr), VW'(p_addr));
            check_output("hold_data", VW'(wr_if.wr_data), VW'(p_data));
        end
        p_hold = (wr_if.wr_en === 1'b1) && !ready && !rst;
        p_addr = wr_if.wr_addr;
        p_data = wr_if.wr_data;
        if (wr_if.wr_en === 1'b1 && ready && !rst) begin
            log_addr.push_back(wr_if.wr_addr);
            log_data.push_back(wr_if.wr_data);
        end
        if (done === 1'b1) begin
            done_cnt++;
            beats_at_done = log_addr.size();
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_live) compare_cycle();
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int sent;
        rst   = 1'b1;
        valid = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        data  = '0;
        base  = '0;
        pix   = '0;
        tick();
        tick();
        check_output("rst_wr_en", VW'(wr_if.wr_en), VW'(0));
        check_output("rst_wr_addr", VW'(wr_if.wr_addr), VW'(0));
        check_output("rst_wr_data", VW'(wr_if.wr_data), VW'(0));
        check_output("rst_busy", VW'(busy), VW'(0));
        check_output("rst_done", VW'(done), VW'(0));
        check_output("rst_overflow", VW'(overflow), VW'(0));
        rst = 1'b0;
        tick();

        $display("[TB] idle vectors and zero-length frame");
        log_addr.delete();
        log_data.delete();
        repeat (3) apply_stimulus(1'b1, rand_vec(), 1'b1);
        start = 1'b1; base = 16'h0200; pix = 16'd0;
        tick();
        start = 1'b0;
        check_output("zero_busy_c1", VW'(busy), VW'(1));
        check_output("zero_done_c1", VW'(done), VW'(0));
        tick();
        check_output("zero_done_c2", VW'(done), VW'(1));
        check_output("zero_busy_c2", VW'(busy), VW'(0));
        tick();
        check_output("zero_done_c3", VW'(done), VW'(0));
        check_output("zero_no_writes", VW'(log_addr.size()), VW'(0));

        $display("[TB] three spaced vectors at base 0x0100");
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start = 1'b1; base = 16'h0100; pix = 16'd3; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, make_vec(k), 1'b1);
            repeat (3) tick();
        end
        wait_done(d0, 50);
        check_output("basic_beats", VW'(log_addr.size()), VW'(6));
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            check_output("basic_addr", VW'(log_addr[i]), VW'(AW'(16'h0100 + i)));
            check_output("basic_data", VW'(log_data[i]), VW'(exp_beat(i / 2, i % 2)));
        end
        check_output("basic_done_once", VW'(done_cnt - d0), VW'(1));
        check_output("basic_done_after_last", VW'(beats_at_done), VW'(6));

        $display("[TB] toggling ready");
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start = 1'b1; base = 16'h0300; pix = 16'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid = (i < 2);
            data  = make_vec(3 + i);
            ready = ((i % 2) == 0);
            tick();
        end
        valid = 1'b0;
        ready = 1'b1;
        wait_done(d0, 20);
        check_output("toggle_beats", VW'(log_addr.size()), VW'(4));
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check_output("toggle_addr", VW'(log_addr[i]), VW'(AW'(16'h0300 + i)));
            check_output("toggle_data", VW'(log_data[i]), VW'(exp_beat(3 + i / 2, i % 2)));
        end

        $display("[TB] address wrap");
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start = 1'b1; base = 16'hFFFF; pix = 16'd1;
        tick();
        start = 1'b0;
        apply_stimulus(1'b1, make_vec(7), 1'b1);
        wait_done(d0, 20);
        check_output("wrap_beats", VW'(log_addr.size()), VW'(2));
        if (log_addr.size() == 2) begin
            check_output("wrap_addr0", VW'(log_addr[0]), VW'(16'hFFFF));
            check_output("wrap_addr1", VW'(log_addr[1]), VW'(16'h0000));
            check_output("wrap_data1", VW'(log_data[1]), VW'(exp_beat(7, 1)));
        end

        $display("[TB] stalled sink with overflow");
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start = 1'b1; base = 16'h0000; pix = 16'd8; ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid = (i < 12);
            data  = make_vec(10 + i);
            ready = 1'b0;
            tick();
        end
        valid = 1'b0;
        check_output("ovf_flag", VW'(overflow), VW'(1));
        check_output("ovf_no_beats", VW'(log_addr.size()), VW'(0));
        ready = 1'b1;
        repeat (30) tick();
        check_output("ovf_beats", VW'(log_addr.size()), VW'(8));
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check_output("ovf_addr", VW'(log_addr[i]), VW'(AW'(i)));
            check_output("ovf_data", VW'(log_data[i]), VW'(exp_beat(10 + i / 2, i % 2)));
        end
        check_output("ovf_still_busy", VW'(busy), VW'(1));
        check_output("ovf_no_done", VW'(done_cnt - d0), VW'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("ovf_cleared", VW'(overflow), VW'(0));

        $display("[TB] reset mid-frame");
        log_addr.delete();
        log_data.delete();
        start = 1'b1; base = 16'h0040; pix = 16'd3; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, make_vec(30 + k), 1'b1);
        for (int n = 0; n < 40 && log_addr.size() < 3; n++) tick();
        check_output("midrst_beats", VW'(log_addr.size()), VW'(3));
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_wr_en", VW'(wr_if.wr_en), VW'(0));
        check_output("midrst_wr_addr", VW'(wr_if.wr_addr), VW'(0));
        check_output("midrst_wr_data", VW'(wr_if.wr_data), VW'(0));
        check_output("midrst_busy", VW'(busy), VW'(0));
        repeat (3) tick();
        check_output("midrst_no_done", VW'(done_cnt - d0), VW'(0));
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start = 1'b1; base = 16'h0500; pix = 16'd1;
        tick();
        start = 1'b0;
        apply_stimulus(1'b1, make_vec(40), 1'b1);
        wait_done(d0, 20);
        check_output("restart_overflow", VW'(overflow), VW'(0));
        check_output("restart_beats", VW'(log_addr.size()), VW'(2));
        if (log_addr.size() == 2) begin
            check_output("restart_addr1", VW'(log_addr[1]), VW'(16'h0501));
            check_output("restart_data0", VW'(log_data[0]), VW'(exp_beat(40, 0)));
        end

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            start = 1'b1;
            base  = AW'($urandom);
            pix   = 16'($urandom_range(1, 6));
            tick();
            start = 1'b0;
            sent  = 0;
            for (int n = 0; n < 300 && (m_run || m_done); n++) begin
                bit go;
                go = (sent < int'(pix) + 2) && ($urandom_range(0, ((f % 2) == 0) ? 3 : 1) == 0);
                valid = go;
                if (go) begin
                    data = rand_vec();
                    sent++;
                end
                ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            valid = 1'b0;
            ready = 1'b1;
            if (m_run) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
